// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with a read-tag FIFO that routes returned read data
// back to its issuer. Define BUS_ARBITER_ROUND_ROBIN_EN for round-robin contention.
module bus_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0Address,
  input  logic [31:0] m1Address,
  input  logic        m0Read,
  input  logic        m1Read,
  input  logic        m0Write,
  input  logic        m1Write,
  input  logic [31:0] m0WriteData,
  input  logic [31:0] m1WriteData,
  output logic        m0WaitRequest,
  output logic        m1WaitRequest,
  output logic        m0ReadValid,
  output logic        m1ReadValid,
  output logic [31:0] readData,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writeData,
  input  logic        waitRequest,
  input  logic        readValid,
  input  logic [31:0] dataIn,
  output logic        orphanError
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic          req0, req1;
  logic          gnt_vld, gnt_id, gnt_rd;
  logic          own_wait;
  logic          full, empty, push, pop, head_id;
  logic          lock_q, lock_d;
  logic          lock_id_q, lock_id_d;
  logic          orphan_q, orphan_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DEPTH-1:0] tag_q;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
  logic          last_q, last_d;
`endif

  assign req0 = m0Read | m0Write;
  assign req1 = m1Read | m1Write;

  always_comb begin
    gnt_vld = req0 | req1;
    gnt_id  = ~req0;
    if (lock_q && (lock_id_q ? req1 : req0)) begin
      gnt_id = lock_id_q;
    end else if (req0 && req1) begin
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
      gnt_id = ~last_q;
`else
      gnt_id = 1'b0;
`endif
    end
    // Read has priority over write when a master raises both.
    gnt_rd = gnt_id ? m1Read : m0Read;
  end

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  assign read      = gnt_vld & gnt_rd & ~full;
  assign write     = gnt_vld & ~gnt_rd;
  assign address   = (gnt_vld & gnt_id) ? m1Address   : m0Address;
  assign writeData = (gnt_vld & gnt_id) ? m1WriteData : m0WriteData;

  assign own_wait      = waitRequest | (gnt_rd & full);
  assign m0WaitRequest = req0 & (gnt_id | own_wait);
  assign m1WaitRequest = req1 & (~gnt_id | own_wait);

  assign push    = read & ~waitRequest;
  assign pop     = readValid & ~empty;
  assign head_id = tag_q[rd_ptr_q];

  assign m0ReadValid = pop & ~head_id;
  assign m1ReadValid = pop & head_id;
  assign readData    = dataIn;
  assign orphanError = orphan_q;

  always_comb begin
    lock_d    = gnt_vld & waitRequest;
    lock_id_d = gnt_id;
    wr_ptr_d  = wr_ptr_q + PW'(push);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    count_d   = count_q + CW'(push) - CW'(pop);
    orphan_d  = orphan_q | (readValid & empty);
  end

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
  assign last_d = ((read | write) & ~waitRequest) ? gnt_id : last_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      orphan_q  <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      orphan_q  <= orphan_d;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tag
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)                            tag_q[gi] <= 1'b0;
        else if (push && wr_ptr_q == PW'(gi))  tag_q[gi] <= gnt_id;
      end
    end
  endgenerate

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized and directed bench for bus_arbiter: a transaction-level model predicts
// bus outputs each cycle and a scoreboard queue checks read returns.
`timescale 1ns/1ps
module tb_bus_arbiter;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0Address, m1Address, m0WriteData, m1WriteData, dataIn;
  logic        m0Read, m1Read, m0Write, m1Write, waitRequest, readValid;
  logic        m0WaitRequest, m1WaitRequest, m0ReadValid, m1ReadValid;
  logic        read, write, orphanError;
  logic [31:0] readData, address, writeData;

  always #5 clk = ~clk;

  bus_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .m0Address(m0Address), .m1Address(m1Address),
    .m0Read(m0Read), .m1Read(m1Read), .m0Write(m0Write), .m1Write(m1Write),
    .m0WriteData(m0WriteData), .m1WriteData(m1WriteData),
    .m0WaitRequest(m0WaitRequest), .m1WaitRequest(m1WaitRequest),
    .m0ReadValid(m0ReadValid), .m1ReadValid(m1ReadValid),
    .readData(readData), .address(address), .read(read), .write(write),
    .writeData(writeData), .waitRequest(waitRequest), .readValid(readValid),
    .dataIn(dataIn), .orphanError(orphanError)
  );

  typedef struct { int id; logic [31:0] data; int stamp; } exp_t;
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state: outstanding read owners in issue order.
  int fifo_m[$];
  int last_m, lock_id_m, g;
  bit lock_m, orphan_m, acc_m;
  bit e_read, e_write, e_w0, e_w1;
  logic [31:0] e_addr, e_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, expv);
    end
  endtask

  task automatic model_reset();
    fifo_m.delete();
    last_m    = 1;
    lock_m    = 0;
    lock_id_m = 0;
    orphan_m  = 0;
  endtask

  task automatic cycle();
    bit r0, r1, gr, full;
    if (!reset) model_reset();
    r0 = m0Read | m0Write;
    r1 = m1Read | m1Write;
    if (lock_m && (lock_id_m == 1 ? r1 : r0)) g = lock_id_m;
    else if (r0 && r1) begin
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
      g = 1 - last_m;
`else
      g = 0;
`endif
    end
    else if (r0) g = 0;
    else if (r1) g = 1;
    else         g = -1;
    full    = (fifo_m.size() == DEPTH);
    gr      = (g == 0) ? m0Read : (g == 1) ? m1Read : 1'b0;
    e_read  = (g >= 0) && gr && !full;
    e_write = (g >= 0) && !gr;
    e_addr  = (g == 1) ? m1Address   : m0Address;
    e_wdata = (g == 1) ? m1WriteData : m0WriteData;
    e_w0    = r0 && (g != 0 || (gr && full) || waitRequest);
    e_w1    = r1 && (g != 1 || (gr && full) || waitRequest);
    acc_m   = (e_read || e_write) && !waitRequest && reset;
    if (reset && readValid && fifo_m.size() > 0)
      exp_q.push_back('{fifo_m[0], dataIn, cyc});
    @(negedge clk);
    chk("read", 32'(read), 32'(e_read));
    chk("write", 32'(write), 32'(e_write));
    chk("address", address, e_addr);
    chk("writeData", writeData, e_wdata);
    chk("m0WaitRequest", 32'(m0WaitRequest), 32'(e_w0));
    chk("m1WaitRequest", 32'(m1WaitRequest), 32'(e_w1));
    chk("readData", readData, dataIn);
    chk("orphanError", 32'(orphanError), 32'(orphan_m));
    @(posedge clk);
    if (reset) begin
      if (readValid) begin
        if (fifo_m.size() > 0) void'(fifo_m.pop_front());
        else                   orphan_m = 1;
      end
      if (acc_m) begin
        last_m = g;
        if (e_read) fifo_m.push_back(g);
      end
      lock_m    = (g >= 0) && waitRequest;
      lock_id_m = g;
    end
    cyc++;
    #1;
  endtask

  // Scoreboard monitor: pops an expectation whenever the DUT strobes a read return.
  always @(negedge clk) begin
    exp_t e;
    if (m0ReadValid || m1ReadValid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_readvalid cycle %0d: got m0=%0b m1=%0b expected none", cyc, m0ReadValid, m1ReadValid);
      end else begin
        e = exp_q.pop_front();
        chk("return_id", {30'b0, m1ReadValid, m0ReadValid}, (e.id == 1) ? 32'd2 : 32'd1);
        chk("return_data", readData, e.data);
        chk("return_cycle", cyc, e.stamp);
        $display("read return cycle %0d master %0d data %h", cyc, e.id, readData);
      end
    end
    if (exp_q.size() > 0 && exp_q[0].stamp <= cyc) begin
      checks++; errors++;
      $display("FAIL missed_readvalid cycle %0d: got no strobe expected master %0d", cyc, exp_q[0].id);
      void'(exp_q.pop_front());
    end
  end

  task automatic idle();
    m0Read = 0; m0Write = 0; m1Read = 0; m1Write = 0;
    waitRequest = 0; readValid = 0; dataIn = $urandom;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && fifo_m.size() > 0; k++) begin
      idle(); readValid = 1; cycle();
    end
  endtask

  task automatic new_req(input int m);
    int k;
    k = $urandom_range(0, 3);
    if (m == 0) begin
      m0Read = (k == 1 || k == 3); m0Write = (k == 2 || k == 3);
      m0Address = $urandom; m0WriteData = $urandom;
    end else begin
      m1Read = (k == 1 || k == 3); m1Write = (k == 2 || k == 3);
      m1Address = $urandom; m1WriteData = $urandom;
    end
  endtask

  logic [31:0] ret_data [0:2];

  initial begin
    ret_data[0] = 32'hA; ret_data[1] = 32'hB; ret_data[2] = 32'hC;
    m0Address = 32'h1000; m1Address = 32'h2000;
    m0WriteData = 32'h1111; m1WriteData = 32'h2222;
    idle();
    reset = 0;
    model_reset();
    @(posedge clk); #1;

    // Reset state, including a readValid that must be ignored
    cycle();
    readValid = 1; cycle();
    idle(); reset = 1;

    // Orphan readValid with nothing outstanding
    readValid = 1; cycle();
    idle(); cycle(); cycle();
    reset = 0; cycle();
    reset = 1; cycle();

    // Both masters reading every cycle
    m0Address = 32'h1000; m1Address = 32'h2000;
    for (int k = 0; k < 8; k++) begin
      m0Read = 1; m1Read = 1; waitRequest = 0;
      readValid = (fifo_m.size() > 0); dataIn = $urandom;
      cycle();
    end
    drain();

    // Locked write stall from m1 while m0 waits
    idle(); m1Write = 1; m1Address = 32'h5100; m1WriteData = 32'h5100;
    waitRequest = 1; cycle();
    m0Read = 1; cycle(); cycle();
    waitRequest = 0; cycle();
    m1Write = 0; cycle();
    idle(); cycle();
    drain();

    // Tag FIFO fill then release by one return
    idle();
    for (int k = 0; k < 6; k++) begin m0Read = 1; cycle(); end
    readValid = 1; cycle();
    readValid = 0; cycle();
    idle(); cycle();
    drain();

    // Interleaved returns routed to the right masters
    for (int k = 0; k < 7; k++) begin
      idle();
      if (k == 0 || k == 2) m0Read = 1;
      if (k == 1) m1Read = 1;
      if (k == 2) begin readValid = 1; dataIn = ret_data[0]; end
      if (k == 3) begin readValid = 1; dataIn = ret_data[1]; end
      if (k == 5) begin readValid = 1; dataIn = ret_data[2]; end
      cycle();
    end

    // Reset with reads outstanding discards them
    idle();
    for (int k = 0; k < 3; k++) begin m0Read = 1; cycle(); end
    idle(); reset = 0; cycle();
    reset = 1; readValid = 1; cycle();
    idle(); cycle();
    reset = 0; cycle();
    reset = 1;

    // Randomized traffic with protocol-following masters
    idle(); new_req(0); new_req(1); acc_m = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!(m0Read | m0Write) || (acc_m && g == 0)) new_req(0);
      if (!(m1Read | m1Write) || (acc_m && g == 1)) new_req(1);
      waitRequest = ($urandom_range(0, 3) == 0);
      readValid   = (fifo_m.size() > 0) && ($urandom_range(0, 2) == 0);
      dataIn      = $urandom;
      cycle();
    end
    drain();
    idle(); cycle();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
